gpio_debounce: RTL and testbench

Per-pin input conditioner that sits directly upstream of the gpio block and drives its gpi input. It runs each raw pad input through a 2-FF synchroniser and a programmable debounce counter, and presents a glitch-free level on gpi_o. It has a small register window on the same simple bus (addr/we/wd/rd) so software can set the debounce period and a per-pin bypass, and can read raw, stable and change state.

---
 rtl/gpio_debounce.sv | 132 +++++++++++++
 tb/tb_gpio_debounce.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// Per-pin 2-FF synchroniser and programmable debouncer feeding gpio.gpi, with a small register window.
// Optional build macro GPIO_DEBOUNCE_IRQ_EN adds IRQ_MASK at 0x14 and an irq output.
module gpio_debounce #(
    parameter int gpio_w     = 8,
    parameter int cnt_w      = 16,
    parameter int rst_period = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic [gpio_w-1:0] pin_i,
    output logic [gpio_w-1:0] gpi_o
`ifdef GPIO_DEBOUNCE_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [gpio_w-1:0] r_s1;
    logic [gpio_w-1:0] r_s2;
    logic [gpio_w-1:0] r_stable;
    logic [gpio_w-1:0] r_bypass;
    logic [gpio_w-1:0] r_change;
    logic [cnt_w-1:0]  r_period;
    logic [cnt_w-1:0]  r_cnt [gpio_w];

    logic [gpio_w-1:0] w_stable_nxt;
    logic [cnt_w-1:0]  w_cnt_nxt [gpio_w];
    logic              w_wr_period;
    logic              w_wr_bypass;
    logic              w_wr_change;
    logic              w_unused;

    assign w_wr_period = we && (addr[7:0] == 8'h00);
    assign w_wr_bypass = we && (addr[7:0] == 8'h04);
    assign w_wr_change = we && (addr[7:0] == 8'h10);
    assign w_unused    = ^{addr[31:8], wd};
    assign gpi_o       = r_stable;

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [gpio_w-1:0] r_irq_mask;
    logic              r_irq;
    logic              w_wr_mask;

    assign w_wr_mask = we && (addr[7:0] == 8'h14);
    assign irq       = r_irq;

    // irq follows the masked sticky change bits one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_mask) begin
                r_irq_mask <= wd[gpio_w-1:0];
            end
            r_irq <= |(r_change & r_irq_mask);
        end
    end
`endif

    // Next-state debounce decision per pin; >= lets a lowered PERIOD commit immediately
    always_comb begin
        for (int i = 0; i < gpio_w; i++) begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = '0;
            if (r_bypass[i]) begin
                w_stable_nxt[i] = r_s2[i];
            end else if (r_s2[i] == r_stable[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] >= r_period) begin
                w_stable_nxt[i] = r_s2[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + cnt_w'(1);
            end
        end
    end

    // Synchroniser, debounce state and software registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_bypass <= '0;
            r_change <= '0;
            r_period <= cnt_w'(rst_period);
            for (int i = 0; i < gpio_w; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1     <= pin_i;
            r_s2     <= r_s1;
            r_stable <= w_stable_nxt;
            for (int i = 0; i < gpio_w; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_wr_period) begin
                r_period <= wd[cnt_w-1:0];
            end
            if (w_wr_bypass) begin
                r_bypass <= wd[gpio_w-1:0];
            end
            // a fresh toggle beats a simultaneous write-1-to-clear
            if (w_wr_change) begin
                r_change <= (r_change & ~wd[gpio_w-1:0]) | (w_stable_nxt ^ r_stable);
            end else begin
                r_change <= r_change | (w_stable_nxt ^ r_stable);
            end
        end
    end

    // Combinational read mux; unmapped addresses and unused bits read zero
    always_comb begin
        rd = '0;
        case (addr[7:0])
            8'h00:   rd[cnt_w-1:0]  = r_period;
            8'h04:   rd[gpio_w-1:0] = r_bypass;
            8'h08:   rd[gpio_w-1:0] = r_s2;
            8'h0C:   rd[gpio_w-1:0] = r_stable;
            8'h10:   rd[gpio_w-1:0] = r_change;
`ifdef GPIO_DEBOUNCE_IRQ_EN
            8'h14:   rd[gpio_w-1:0] = r_irq_mask;
`endif
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: register table plus hand-written timing sequences.
module tb_gpio_debounce;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  pin_i;
    logic [7:0]  gpi_o;
`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic        irq;
    localparam logic [31:0] EXP_MASK = 32'h0000_00A5;
`else
    localparam logic [31:0] EXP_MASK = 32'h0000_0000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gpio_debounce dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .pin_i (pin_i),
        .gpi_o (gpi_o)
`ifdef GPIO_DEBOUNCE_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = {24'h0, a};
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [7:0] a, input logic [31:0] exp);
        addr = {24'h0, a};
        #1;
        check(name, rd, exp);
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 32'h0;
        we    = 1'b0;
        wd    = 32'h0;
        pin_i = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'd100};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 8'h0C, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 8'h10, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 8'h04, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[6]  = '{1'b1, 8'h04, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 8'h00, 32'hABCD_1234, 32'h0000_1234};
        vecs[8]  = '{1'b1, 8'h08, 32'h0000_00FF, 32'h0};
        vecs[9]  = '{1'b0, 8'h18, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 8'h14, 32'hFFFF_FFA5, EXP_MASK};

        check("reset_gpi", {24'h0, gpi_o}, 32'h0);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].a, vecs[i].d);
            end
            rdchk($sformatf("regvec%0d", i), vecs[i].a, vecs[i].exp);
        end
        wr(8'h14, 32'h0);

        // clean edge, PERIOD=4: gpi rises on the 7th edge
        wr(8'h00, 32'd4);
        pin_i = 8'h01;
        for (int i = 0; i < 6; i++) tick();
        check("clean_before", {24'h0, gpi_o}, 32'h0);
        tick();
        check("clean_rise", {24'h0, gpi_o}, 32'h01);
        rdchk("clean_change", 8'h10, 32'h01);
        wr(8'h10, 32'h01);
        rdchk("clean_w1c", 8'h10, 32'h00);
        pin_i = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        wr(8'h10, 32'hFF);

        // glitch of 3 cycles on pin 1
        pin_i = 8'h02;
        for (int i = 0; i < 3; i++) tick();
        pin_i = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        check("glitch_gpi", {24'h0, gpi_o}, 32'h0);
        rdchk("glitch_change", 8'h10, 32'h0);

        // period shrink mid-count
        wr(8'h00, 32'd50);
        pin_i = 8'h04;
        for (int i = 0; i < 20; i++) tick();
        wr(8'h00, 32'd5);
        check("shrink_at_write", {24'h0, gpi_o}, 32'h0);
        tick();
        check("shrink_commit", {24'h0, gpi_o}, 32'h04);
        pin_i = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        wr(8'h10, 32'hFF);

        // bypass on pin 7, pin 6 debounced with PERIOD=1000
        wr(8'h04, 32'h80);
        wr(8'h00, 32'd1000);
        pin_i = 8'hC0;
        tick();
        tick();
        check("byp_before", {24'h0, gpi_o}, 32'h0);
        tick();
        check("byp_follow", {24'h0, gpi_o}, 32'h80);
        for (int i = 0; i < 999; i++) tick();
        check("slow_before", {24'h0, gpi_o}, 32'h80);
        tick();
        check("slow_rise", {24'h0, gpi_o}, 32'hC0);
        rdchk("byp_change", 8'h10, 32'hC0);
        pin_i = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        check("byp_fall", {24'h0, gpi_o}, 32'h40);
        for (int i = 0; i < 1000; i++) tick();
        check("slow_fall", {24'h0, gpi_o}, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h10, 32'hFF);

        // PERIOD=0: three edges pin to gpi
        wr(8'h00, 32'd0);
        pin_i = 8'h08;
        tick();
        tick();
        check("p0_before", {24'h0, gpi_o}, 32'h0);
        tick();
        check("p0_rise", {24'h0, gpi_o}, 32'h08);
        pin_i = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        wr(8'h10, 32'hFF);

        // reset in the middle of a count: no stale commit afterwards
        wr(8'h00, 32'd4);
        pin_i = 8'h10;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midrst_gpi", {24'h0, gpi_o}, 32'h0);
        rdchk("midrst_period", 8'h00, 32'd100);
        pin_i = 8'h00;
        for (int i = 0; i < 5; i++) tick();

        // W1C on the same edge stable[0] toggles: set wins
        wr(8'h00, 32'd0);
        wr(8'h14, 32'h01);
        pin_i = 8'h01;
        tick();
        tick();
        wr(8'h10, 32'h01);
        rdchk("w1c_race_change", 8'h10, 32'h01);
        tick();
`ifdef GPIO_DEBOUNCE_IRQ_EN
        check("w1c_race_irq", {31'h0, irq}, 32'h1);
`endif
        wr(8'h10, 32'h01);
        rdchk("w1c_final_change", 8'h10, 32'h00);
`ifdef GPIO_DEBOUNCE_IRQ_EN
        check("irq_hold", {31'h0, irq}, 32'h1);
        tick();
        check("irq_clear", {31'h0, irq}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
